// File: rtl/buffer_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : buffer_drain
// Purpose  : Read-side controller for a FWFT buffer FIFO. A start command pops
//            exactly burst_len_i words from the FIFO. The words leave on a
//            valid/ready stream through a 2-entry output queue. The pop request
//            depends only on registered state and fifo_empty_i, so there is no
//            combinational path from m_ready_i to fifo_rd_en_o.
// Ports    : clk_i, rst_ni (async, active-low)
//            start_i, burst_len_i       : command; the length is sampled when
//                                         the command is accepted
//            busy_o, done_o             : status; done_o pulses for one cycle
//                                         at the end of a burst
//            fifo_empty_i, fifo_dout_i,
//            fifo_rd_en_o               : FWFT FIFO read side
//            m_data_o, m_valid_o,
//            m_ready_i                  : output stream
//            m_last_o                   : last-word flag (optional)
// Options  : define BUFFER_DRAIN_LAST_EN to add the m_last_o port.
// Revision : 1.0 - initial release
// ============================================================================
module buffer_drain #(
  parameter int DWIDTH = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_dout_i,
  output logic              fifo_rd_en_o,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i
`ifdef BUFFER_DRAIN_LAST_EN
  ,
  output logic              m_last_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d;   // words still to pop from the FIFO
  logic [LEN_W-1:0]  tx_left_q, tx_left_d;   // words still to hand to the consumer
  logic [1:0]        occ_q, occ_d;           // output queue occupancy, 0..2
  logic [DWIDTH-1:0] q0_q, q0_d;             // queue head
  logic [DWIDTH-1:0] q1_q, q1_d;             // queue second entry
  logic              done_q, done_d;

  logic push;
  logic pop;

  // Pop request uses only registered state and fifo_empty_i.
  assign push = (state_q == RUN) && !fifo_empty_i &&
                (rd_left_q != '0) && (occ_q != 2'd2);
  assign pop  = (occ_q != 2'd0) && m_ready_i;

  assign fifo_rd_en_o = push;
  assign m_valid_o    = (occ_q != 2'd0);
  assign m_data_o     = q0_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

`ifdef BUFFER_DRAIN_LAST_EN
  assign m_last_o = (occ_q != 2'd0) && (tx_left_q == LEN_W'(1));
`endif

  always_comb begin
    state_d   = state_q;
    rd_left_d = rd_left_q;
    tx_left_d = tx_left_q;
    occ_d     = occ_q;
    q0_d      = q0_q;
    q1_d      = q1_q;
    done_d    = 1'b0;

    // Output queue. A push never coincides with occ_q == 2 because the pop
    // request is blocked there.
    case (occ_q)
      2'd0: begin
        if (push) begin
          q0_d  = fifo_dout_i;
          occ_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          q0_d = fifo_dout_i;
        end else if (push) begin
          q1_d  = fifo_dout_i;
          occ_d = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          q0_d  = q1_q;
          occ_d = 2'd1;
        end
      end
    endcase

    if (push) begin
      rd_left_d = rd_left_q - LEN_W'(1);
    end
    if (pop) begin
      tx_left_d = tx_left_q - LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (burst_len_i != '0) begin
            state_d   = RUN;
            rd_left_d = burst_len_i;
            tx_left_d = burst_len_i;
          end else begin
            // Zero-length burst completes immediately.
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (push && (rd_left_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (tx_left_q == LEN_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rd_left_q <= '0;
      tx_left_q <= '0;
      occ_q     <= 2'd0;
      q0_q      <= '0;
      q1_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_left_q <= rd_left_d;
      tx_left_q <= tx_left_d;
      occ_q     <= occ_d;
      q0_q      <= q0_d;
      q1_q      <= q1_d;
      done_q    <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buffer_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_buffer_drain
// Purpose  : Self-checking bench for buffer_drain. It includes a FWFT FIFO
//            model, a scoreboard queue of written words and a monitor that
//            predicts the burst behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic        busy, done, fifo_rd_en, m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
`ifdef BUFFER_DRAIN_LAST_EN
  logic        m_last;
`endif

  always #5 clk = ~clk;

  buffer_drain #(.DWIDTH(16), .LEN_W(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .burst_len_i  (burst_len),
    .busy_o       (busy),
    .done_o       (done),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_rd_en_o (fifo_rd_en),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready)
`ifdef BUFFER_DRAIN_LAST_EN
    ,
    .m_last_o     (m_last)
`endif
  );

  // FWFT buffer model; it is not affected by the controller reset.
  logic [15:0] mem [0:4095];
  logic [11:0] wr_ptr = '0;
  logic [11:0] rd_ptr = '0;
  logic        fifo_wr = 1'b0;
  logic [15:0] fifo_wdata = '0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= fifo_wdata;
      wr_ptr      <= wr_ptr + 12'd1;
    end
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      rd_ptr <= rd_ptr + 12'd1;
    end
  end

  // Consumer ready: 0 = always ready, 1 = random, 2 = never ready.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      default: m_ready = 1'b0;
    endcase
  end
  initial m_ready = 1'b0;

  // Scoreboard and reference model state.
  logic [15:0] exp_q [$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  occ_m    = 0;
  int  rd_owed  = 0;
  int  tx_owed  = 0;
  bit  busy_m   = 1'b0;
  bit  done_m   = 1'b0;
  bit  stall_prev = 1'b0;
  logic [15:0] prev_data = '0;
  bit  timeout_flag = 1'b0;
  bit  end_req  = 1'b0;
  bit  end_done = 1'b0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge and predicts the next rising edge.
  always @(negedge clk) begin
    bit hs, exp_rd, done_n, lastv;
    if (!rst_n) begin
      lastv = 1'b0;
`ifdef BUFFER_DRAIN_LAST_EN
      lastv = m_last;
`endif
      check({m_data, busy, done, fifo_rd_en, m_valid, lastv} == '0, "reset_outputs",
            {11'd0, m_data, busy, done, fifo_rd_en, m_valid, lastv}, 32'd0);
      // Words already popped from the FIFO but not delivered are lost.
      repeat (occ_m) if (exp_q.size() > 0) void'(exp_q.pop_front());
      occ_m = 0; rd_owed = 0; tx_owed = 0;
      busy_m = 1'b0; done_m = 1'b0; stall_prev = 1'b0;
    end else begin
      exp_rd = busy_m && (rd_owed != 0) && !fifo_empty && (occ_m != 2);
      check(done == done_m, "done", done, done_m);
      check(busy == busy_m, "busy", busy, busy_m);
      check(m_valid == (occ_m != 0), "m_valid", m_valid, occ_m != 0);
      check(fifo_rd_en == exp_rd, "fifo_rd_en", fifo_rd_en, exp_rd);
      if (stall_prev) begin
        check(m_valid && (m_data == prev_data), "stall_hold", m_data, prev_data);
      end
`ifdef BUFFER_DRAIN_LAST_EN
      check(m_last == (m_valid && (tx_owed == 1)), "m_last", m_last,
            m_valid && (tx_owed == 1));
`endif
      hs = m_valid && m_ready;
      if (hs) begin
        if ((exp_q.size() == 0) || (tx_owed == 0)) begin
          check(1'b0, "extra_word", m_data, 32'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check(m_data == e, "m_data", m_data, e);
        end
      end
      done_n = 1'b0;
      if (fifo_rd_en) begin
        if (rd_owed > 0) rd_owed--;
        if (occ_m < 2) occ_m++;
      end
      if (hs) begin
        if (occ_m > 0) occ_m--;
        if (tx_owed > 0) begin
          tx_owed--;
          if (tx_owed == 0) begin
            busy_m = 1'b0;
            done_n = 1'b1;
          end
        end
      end else if (start && !busy_m) begin
        if (burst_len != 0) begin
          busy_m  = 1'b1;
          rd_owed = burst_len;
          tx_owed = burst_len;
        end else begin
          done_n = 1'b1;
        end
      end
      done_m     = done_n;
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
    end
    if (end_req && !end_done) begin
      check(exp_q.size() == 0, "all_words_delivered", exp_q.size(), 0);
      check(rd_ptr == wr_ptr, "fifo_drained", rd_ptr, wr_ptr);
      check(!timeout_flag, "burst_timeout", timeout_flag, 0);
      end_done = 1'b1;
    end
  end

  task automatic push_words(input int n, input bit seq, input int base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      fifo_wr    = 1'b1;
      fifo_wdata = seq ? 16'(base + i) : 16'($urandom);
      exp_q.push_back(fifo_wdata);
    end
    @(posedge clk); #1;
    fifo_wr = 1'b0;
  endtask

  task automatic do_start(input int len);
    @(posedge clk); #1;
    start     = 1'b1;
    burst_len = 16'(len);
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (busy && (c < 3000)) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 3000) timeout_flag = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, len;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 0;

    // Directed burst of 8 sequential words.
    push_words(8, 1'b1, 1);
    do_start(8);
    wait_done();

    // Partial burst: 4 of 6 words; 5 and 6 stay in the FIFO.
    push_words(6, 1'b1, 1);
    do_start(4);
    wait_done();

    // 16-word burst with a random consumer and an ignored start while busy.
    push_words(14, 1'b0, 0);
    rdy_mode = 1;
    do_start(16);
    repeat (5) @(posedge clk);
    do_start(3);
    wait_done();

    // FIFO runs dry after 3 of 5 words and refills later.
    rdy_mode = 0;
    push_words(3, 1'b0, 0);
    do_start(5);
    repeat (10) @(posedge clk);
    push_words(2, 1'b0, 0);
    wait_done();

    // Zero-length burst.
    do_start(0);
    repeat (3) @(posedge clk);

    // Reset while the output queue is full.
    rdy_mode = 2;
    push_words(8, 1'b0, 0);
    do_start(5);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 1;
    do_start(exp_q.size());
    wait_done();

    // Random bursts.
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 6);
      push_words(n, 1'b0, 0);
      len = $urandom_range(0, exp_q.size());
      do_start(len);
      wait_done();
    end

    if (exp_q.size() > 0) begin
      do_start(exp_q.size());
      wait_done();
    end
    repeat (2) @(posedge clk);
    end_req = 1'b1;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/buffer_drain.md
# buffer_drain

Read-side controller for the accelerator's FWFT `buffer` FIFO. On a `start` command it pops exactly `burst_len` words from the FIFO and presents them on a valid/ready output stream through a 2-entry output queue. The queue sustains one word per cycle without a combinational path from `m_ready` to `fifo_rd_en`. It sits between an operand/result `buffer` and its downstream consumer, such as the systolic array feeder or the result writeback.

## Interface
Parameters:
- `DWIDTH`, 16, data word width; must match the attached `buffer`.
- `LEN_W`, 16, width of the burst length and internal counters.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle command pulse; ignored while `busy`.
- `burst_len`  in  LEN_W  number of words to transfer; sampled when `start` is accepted.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when a burst completes.
- `fifo_empty`  in  1  `empty` from the `buffer`.
- `fifo_dout`  in  DWIDTH  `dout` from the `buffer`; first-word-fall-through (FWFT), valid whenever `!fifo_empty`.
- `fifo_rd_en`  out  1  pop request to the `buffer`.
- `m_data`  out  DWIDTH  output word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_last`  out  1  present only with `BUFFER_DRAIN_LAST_EN` (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE, `start` with `burst_len != 0`: latch `rd_left = burst_len` and `tx_left = burst_len`, go to RUN.
- IDLE, `start` with `burst_len == 0`: stay in IDLE; pulse `done` in the next cycle.
- Pop condition: `fifo_rd_en = (state==RUN) && !fifo_empty && rd_left!=0 && occ!=2`.
  - Purely a function of registered state and `fifo_empty`.
- When `fifo_rd_en` is high, `fifo_dout` is written into the queue tail at the same edge and `rd_left` decrements.
- RUN -> DRAIN at the edge where `rd_left` goes 1 -> 0.
- Output queue:
  - `occ` ranges 0..2.
  - `m_valid = occ!=0`; `m_data` is the head entry.
  - A handshake (`m_valid && m_ready`) pops the head and decrements `tx_left`.
  - Simultaneous push and pop leaves `occ` unchanged and preserves data order.
- `m_data` holds its value while `m_valid && !m_ready`.
- Completion: at the edge where `tx_left` goes 1 -> 0, go to IDLE and register `done=1` for exactly one cycle. `busy` falls in that same cycle.
- `start` while `busy` is ignored; no queueing of commands.
- FIFO empty mid-burst: `fifo_rd_en` stays low and the burst resumes when data arrives. There is no timeout.
- Counters never wrap; bursts up to 2^LEN_W-1 words.
- Reset, including mid-burst:
  - State is IDLE, `occ=0`, and both counters are 0.
  - `m_data=0`, `m_valid=0`, `fifo_rd_en=0`, `busy=0`, `done=0`, `m_last=0`.
  - Queued words are discarded; no FIFO words are returned.

## Timing
- `start` sampled at edge E0 -> RUN in cycle 1 -> `fifo_rd_en` can assert in cycle 1 -> `m_valid` high in cycle 2. Start-to-first-word latency is 2 cycles.
- Steady state with `m_ready=1` and the FIFO non-empty: one word per cycle, `occ=1`, no bubbles.
- `m_ready` low: at most 2 words are buffered. `fifo_rd_en` then deasserts in the cycle where `occ==2`.
- Final handshake at edge EN -> `done=1` and `busy=0` during cycle N+1. A new `start` is accepted at the edge ending cycle N+1.

## Configuration
- `BUFFER_DRAIN_LAST_EN` defined:
  - The `m_last` port exists.
  - `m_last` is high whenever `m_valid` is high and the head word is the final word of the burst (`tx_left==1`).
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- FIFO preloaded with 0x0001..0x0008, `m_ready=1`, `start` with `burst_len=8` -> `m_data` 0x0001..0x0008 on 8 consecutive cycles starting 2 cycles after `start`; `done` one cycle after the last word; FIFO empty afterwards.
- `burst_len=4` with 6 words in the FIFO -> exactly 4 words popped; 2 words remain (0x0005, 0x0006); `fifo_rd_en` never high in IDLE.
- `m_ready` toggling 1,0,0,1 pseudo-randomly over a 16-word burst -> order preserved; `m_data` stable while stalled; `occ` never exceeds 2; `fifo_rd_en` low whenever `occ==2`.
- FIFO empties after 3 of 5 words, then refills 10 cycles later -> `busy` stays high; the remaining 2 words are delivered; `done` fires once.
- `burst_len=0` -> `done` pulse next cycle; no `fifo_rd_en`; `m_valid` stays 0. `start` while busy -> ignored.
- `rst` asserted mid-burst with `occ==2` -> all outputs 0 immediately (async); after release, a new burst delivers the FIFO's next words correctly. With `BUFFER_DRAIN_LAST_EN`, `m_last` is high only on the final word.
